inst_mem_loader: RTL and testbench

- Writer side of the instruction-memory interface: receives a byte stream from a host or debug link and writes it into the byte-cell instruction memory that the fetch stage reads.
- Holds the CPU while loading.
- Assembles each 4-byte instruction and checks its opcode field against the legal opcode_t encodings.
- Sits between the host byte link and the instruction memory write port, alongside the pipeline.

---
 rtl/inst_mem_loader.sv | 155 +++++++++++++++
 tb/tb_inst_mem_loader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Host byte-stream loader for the byte-cell instruction memory.
// Holds the CPU while loading, writes big-endian words and flags illegal opcodes.
module inst_mem_loader #(
  parameter int N             = 32,
  parameter int INST_MEM_SIZE = 1024,
  parameter int MEM_CELL_SIZE = 8,
  parameter int OP_CODE_LEN   = 6,
  parameter int AW            = $clog2(INST_MEM_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [AW-1:0]            base_addr,
  input  logic [AW-2:0]            word_count,
  input  logic                     s_valid,
  input  logic [MEM_CELL_SIZE-1:0] s_data,
  output logic                     s_ready,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [MEM_CELL_SIZE-1:0] mem_wdata,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [AW-2:0]            bad_count,
  output logic [N-1:0]             last_word
);

  // state | meaning
  // IDLE  | waiting for start, CPU free
  // LOAD  | accepting host bytes, one cell write per byte
  // CHECK | word complete: capture it and check the opcode
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

  localparam logic [AW+1:0] MEM_LIMIT = (AW+2)'(INST_MEM_SIZE);

  state_t                   state_q, state_d;
  logic [AW-1:0]            addr_q;
  logic [AW-2:0]            cnt_q;
  logic [AW-2:0]            word_cnt_q;
  logic [1:0]               byte_idx_q;
  logic [N-1:0]             word_q;
  logic                     mem_we_q;
  logic [AW-1:0]            mem_addr_q;
  logic [MEM_CELL_SIZE-1:0] mem_wdata_q;
  logic                     err_q;
  logic [AW-2:0]            bad_count_q;
  logic [N-1:0]             last_word_q;

  logic [AW-1:0] base_al;
  logic [AW+1:0] end_addr;
  logic          count_zero;
  logic          bounds_bad;
  logic          last_byte;

  function automatic logic op_legal(input logic [OP_CODE_LEN-1:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000011, 6'b000101, 6'b000110, 6'b000111,
      6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100,
      6'b100000, 6'b100001, 6'b100100, 6'b100101,
      6'b101000, 6'b101001, 6'b101010: op_legal = 1'b1;
      default:                         op_legal = 1'b0;
    endcase
  endfunction

  // Range check is done one bit wider than the address so it cannot wrap.
  assign base_al    = {base_addr[AW-1:2], 2'b00};
  assign end_addr   = {2'b00, base_al} + {1'b0, word_count, 2'b00};
  assign count_zero = (word_count == '0);
  assign bounds_bad = !count_zero && (end_addr > MEM_LIMIT);
  assign last_byte  = s_valid && (byte_idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count_zero || bounds_bad) state_d = DONE;
          else                          state_d = LOAD;
        end
      end
      LOAD:    if (last_byte) state_d = CHECK;
      CHECK:   state_d = (word_cnt_q == cnt_q) ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      cnt_q       <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      bad_count_q <= '0;
      last_word_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q      <= base_al;
            cnt_q       <= word_count;
            word_cnt_q  <= '0;
            byte_idx_q  <= '0;
            bad_count_q <= '0;
            err_q       <= bounds_bad;
          end
        end
        LOAD: begin
          if (s_valid) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= s_data;
            addr_q      <= addr_q + AW'(1);
            word_q      <= {word_q[N-MEM_CELL_SIZE-1:0], s_data};
            byte_idx_q  <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) word_cnt_q <= word_cnt_q + (AW-1)'(1);
          end
        end
        CHECK: begin
          last_word_q <= word_q;
          if (!op_legal(word_q[N-1 -: OP_CODE_LEN])) begin
            err_q <= 1'b1;
            if (bad_count_q != '1) bad_count_q <= bad_count_q + (AW-1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready   = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign cpu_hold  = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign bad_count = bad_count_q;
  assign last_word = last_word_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader: per-byte write timing,
// opcode checking, bounds handling, async reset and host stalls.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [8:0]  word_count = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, mem_we, cpu_hold, busy, done, err;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [8:0]  bad_count;
  logic [31:0] last_word;

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int done_cnt = 0;
  logic [7:0] tb_mem [0:1023];

  inst_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .err(err), .bad_count(bad_count), .last_word(last_word)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      tb_mem[mem_addr] = mem_wdata;
      wr_count++;
    end
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded, bad=%0d", bad);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic [9:0] exp_addr);
    int n;
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    while (s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready: s_ready=%b required 1", s_ready);
    end
    @(negedge clk);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== b) begin
      bad++;
      $display("FAIL write_%03h: we=%b addr=%03h data=%02h required we=1 addr=%03h data=%02h",
               exp_addr, mem_we, mem_addr, mem_wdata, exp_addr, b);
    end
  endtask

  task automatic do_start(input logic [9:0] base, input logic [8:0] cnt);
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL start_hold: busy=%b cpu_hold=%b required 1 1", busy, cpu_hold);
    end
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s_done: done=%b required 1 within %0d cycles", name, done, max_cyc);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s_release: busy=%b cpu_hold=%b done=%b required 0 0 0",
               name, busy, cpu_hold, done);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({s_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0 ||
        mem_addr !== 10'h0 || mem_wdata !== 8'h0 || bad_count !== 9'h0 ||
        last_word !== 32'h0) begin
      bad++;
      $display("FAIL %s: rdy=%b we=%b hold=%b busy=%b done=%b err=%b addr=%03h wd=%02h bc=%0d lw=%08h required all 0",
               name, s_ready, mem_we, cpu_hold, busy, done, err, mem_addr,
               mem_wdata, bad_count, last_word);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");
  endtask

  task automatic test_two_words();
    logic [7:0] bytes [8];
    bytes = '{8'h04, 8'h22, 8'h18, 8'h00, 8'h8C, 8'h41, 8'h00, 8'h10};
    do_start(10'h010, 9'd2);
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 10'h010 + 10'(i));
    total++;
    if (s_ready !== 1'b0) begin
      bad++;
      $display("FAIL two_gap1: s_ready=%b required 0", s_ready);
    end
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || last_word !== 32'h04221800 || bad_count !== 9'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL two_word1: rdy=%b lw=%08h bc=%0d err=%b required 1 04221800 0 0",
               s_ready, last_word, bad_count, err);
    end
    for (int i = 4; i < 8; i++) send_byte(bytes[i], 10'h010 + 10'(i));
    total++;
    if (s_ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL two_gap2: s_ready=%b done=%b required 0 0", s_ready, done);
    end
    s_valid = 1'b0;
    wait_done(3, "two");
    // 0x8C carries opcode 100011, which is not a legal encoding.
    total++;
    if (last_word !== 32'h8C410010 || bad_count !== 9'd1 || err !== 1'b1) begin
      bad++;
      $display("FAIL two_result: lw=%08h bc=%0d err=%b required 8c410010 1 1",
               last_word, bad_count, err);
    end
  endtask

  task automatic test_reset_mid();
    do_start(10'h040, 9'd1);
    send_byte(8'h04, 10'h040);
    send_byte(8'h11, 10'h041);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid");
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    do_start(10'h000, 9'd1);
    send_byte(8'hFC, 10'h000);
    send_byte(8'h00, 10'h001);
    send_byte(8'h00, 10'h002);
    send_byte(8'h00, 10'h003);
    s_valid = 1'b0;
    wait_done(3, "illegal");
    total++;
    if (last_word !== 32'hFC000000 || bad_count !== 9'd1 || err !== 1'b1) begin
      bad++;
      $display("FAIL illegal_result: lw=%08h bc=%0d err=%b required fc000000 1 1",
               last_word, bad_count, err);
    end
  endtask

  task automatic test_count_zero();
    int w0;
    w0 = wr_count;
    do_start(10'h080, 9'd0);
    total++;
    if (done !== 1'b1 || err !== 1'b0 || bad_count !== 9'd0) begin
      bad++;
      $display("FAIL zero_flags: done=%b err=%b bc=%0d required 1 0 0", done, err, bad_count);
    end
    wait_done(2, "zero");
    total++;
    if (wr_count != w0) begin
      bad++;
      $display("FAIL zero_writes: writes=%0d required 0", wr_count - w0);
    end
  endtask

  task automatic test_bounds();
    int w0;
    w0 = wr_count;
    do_start(10'h3FC, 9'd2);
    wait_done(2, "oob");
    total++;
    if (err !== 1'b1 || wr_count != w0) begin
      bad++;
      $display("FAIL oob_result: err=%b writes=%0d required 1 0", err, wr_count - w0);
    end
    // Low address bits are dropped, so 0x3FE loads from 0x3FC.
    do_start(10'h3FE, 9'd1);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL edge_err_clear: err=%b required 0", err);
    end
    send_byte(8'h20, 10'h3FC);
    send_byte(8'hA5, 10'h3FD);
    send_byte(8'h5A, 10'h3FE);
    send_byte(8'hFF, 10'h3FF);
    s_valid = 1'b0;
    wait_done(3, "edge");
    total++;
    if (err !== 1'b0 || wr_count != w0 + 4 || last_word !== 32'h20A55AFF) begin
      bad++;
      $display("FAIL edge_result: err=%b writes=%0d lw=%08h required 0 4 20a55aff",
               err, wr_count - w0, last_word);
    end
  endtask

  task automatic test_start_ignored();
    int w0;
    w0 = wr_count;
    do_start(10'h100, 9'd1);
    send_byte(8'h28, 10'h100);
    send_byte(8'h01, 10'h101);
    s_valid    = 1'b0;
    start      = 1'b1;
    base_addr  = 10'h000;
    word_count = 9'd5;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h02, 10'h102);
    send_byte(8'h03, 10'h103);
    s_valid = 1'b0;
    wait_done(3, "ignored");
    total++;
    if (wr_count != w0 + 4 || last_word !== 32'h28010203) begin
      bad++;
      $display("FAIL ignored_result: writes=%0d lw=%08h required 4 28010203",
               wr_count - w0, last_word);
    end
  endtask

  task automatic test_random_gaps();
    logic [5:0] legal_ops [18];
    logic [7:0] exp_bytes [64];
    logic [31:0] exp_last;
    int w0, d0, g;
    legal_ops = '{6'h00, 6'h01, 6'h03, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A,
                  6'h0B, 6'h0C, 6'h20, 6'h21, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2A};
    for (int i = 0; i < 64; i++) begin
      if (i % 4 == 0)
        exp_bytes[i] = {legal_ops[$urandom_range(0, 17)], 2'($urandom_range(0, 3))};
      else
        exp_bytes[i] = 8'($urandom_range(0, 255));
    end
    exp_last = {exp_bytes[60], exp_bytes[61], exp_bytes[62], exp_bytes[63]};
    w0 = wr_count;
    do_start(10'h200, 9'd16);
    d0 = done_cnt;
    for (int i = 0; i < 64; i++) begin
      g = $urandom_range(0, 7);
      s_valid = 1'b0;
      s_data  = 8'($urandom_range(0, 255));
      repeat (g) @(negedge clk);
      send_byte(exp_bytes[i], 10'h200 + 10'(i));
    end
    s_valid = 1'b0;
    total++;
    if (done_cnt != d0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rand_early_done: pulses=%0d done=%b required 0 0", done_cnt - d0, done);
    end
    wait_done(3, "rand");
    total++;
    if (wr_count != w0 + 64 || done_cnt != d0 + 1) begin
      bad++;
      $display("FAIL rand_counts: writes=%0d dones=%0d required 64 1",
               wr_count - w0, done_cnt - d0);
    end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (tb_mem[10'h200 + 10'(i)] !== exp_bytes[i]) begin
        bad++;
        $display("FAIL rand_mem_%03h: got %02h required %02h",
                 10'h200 + 10'(i), tb_mem[10'h200 + 10'(i)], exp_bytes[i]);
      end
    end
    total++;
    if (bad_count !== 9'd0 || err !== 1'b0 || last_word !== exp_last) begin
      bad++;
      $display("FAIL rand_result: bc=%0d err=%b lw=%08h required 0 0 %08h",
               bad_count, err, last_word, exp_last);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_two_words();
    test_reset_mid();
    test_illegal();
    test_count_zero();
    test_bounds();
    test_start_ignored();
    test_random_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
